// File: rtl/mem_port_arbiter_if.sv
// Shared-memory-port arbiter bus bundle: requester request/response lanes
// (flat-packed, slot n at bits [W*(n+1)-1 : W*n]) plus the single shared port.
//   slave  : the arbiter side (samples requests, drives the shared port)
//   master : the environment side (requesters and memory)
interface mem_port_arbiter_if #(
  parameter int unsigned NR_REQ = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned MASK_W = DATA_W / 8;

  // requester side
  logic [NR_REQ-1:0]        req_valid;
  logic [NR_REQ-1:0]        req_ready;
  logic [NR_REQ*ADDR_W-1:0] req_addr;
  logic [NR_REQ-1:0]        req_wen;
  logic [NR_REQ*DATA_W-1:0] req_wdata;
  logic [NR_REQ*MASK_W-1:0] req_wmask;
  logic [NR_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata;

  // shared memory port
  logic                     mem_valid;
  logic                     mem_ready;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_wen;
  logic [DATA_W-1:0]        mem_wdata;
  logic [MASK_W-1:0]        mem_wmask;
  logic                     mem_rsp_valid;
  logic [DATA_W-1:0]        mem_rsp_rdata;

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port between NR_REQ
// requesters (slot 0 = IFU, slot 1 = LSU). One request is accepted at a time,
// replayed on the shared port, and the grant is held until the response
// returns; the response is then routed to the owning slot.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   bus (slave)   requester lanes (req_*, rsp_*) and shared port (mem_*)
//   busy          1 whenever the FSM is not idle
//   grant_id      slot holding the grant; valid while busy
//   err_spurious  one-cycle pulse after a memory response outside a wait
module mem_port_arbiter #(
  parameter  int unsigned NR_REQ = 2,
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned IDX_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 err_spurious
);
  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    rr_next_c;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand;
  logic                win_found;
  logic [NR_REQ-1:0]   req_ready_c;
  logic                resp_done_c;
  logic                spurious_c;

  logic [NR_REQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                mem_valid_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_wen_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [MASK_W-1:0]   mem_wmask_q;

  // Winner: first valid slot searching rr_ptr, rr_ptr+1, ... modulo NR_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      cand = IDX_W'((32'(rr_ptr) + i) % NR_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Accept is combinational and only ever offered while idle
  always_comb begin
    req_ready_c = '0;
    if (state == S_IDLE && win_found) begin
      req_ready_c = NR_REQ'(1) << win_idx;
    end
  end

  // A response completes the transaction in WAIT, or in ISSUE when it
  // arrives together with mem_ready; anything else is spurious
  always_comb begin
    resp_done_c = bus.mem_rsp_valid &&
                  ((state == S_WAIT) || (state == S_ISSUE && bus.mem_ready));
    spurious_c  = bus.mem_rsp_valid && !resp_done_c;
    rr_next_c   = (grant_id == IDX_W'(NR_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      busy         <= 1'b0;
      err_spurious <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wen_q    <= 1'b0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
    end else begin
      err_spurious <= spurious_c;
      rsp_valid_q  <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            mem_addr_q  <= bus.req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wen_q   <= bus.req_wen[win_idx];
            mem_wdata_q <= bus.req_wdata[win_idx*DATA_W +: DATA_W];
            mem_wmask_q <= bus.req_wmask[win_idx*MASK_W +: MASK_W];
            grant_id    <= win_idx;
            mem_valid_q <= 1'b1;
            busy        <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.mem_ready) begin
            mem_valid_q <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: ;
        default: state <= S_IDLE;
      endcase
      // Completion overrides the ISSUE->WAIT move for the combined handshake
      if (resp_done_c) begin
        rsp_rdata_q <= bus.mem_rsp_rdata;
        rsp_valid_q <= NR_REQ'(1) << grant_id;
        rr_ptr      <= rr_next_c;
        mem_valid_q <= 1'b0;
        busy        <= 1'b0;
        state       <= S_IDLE;
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
endmodule
